// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/result handshake bundle for imm_encoder
interface imm_encoder_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       imm_src;
   logic [31:0]      imm;
   logic             out_valid;
   logic             out_ready;
   logic [24:0]      out_enc;
   logic [24:0]      out_mask;
   logic [1:0]       out_err;
   logic             err_clr;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output in_valid, imm_src, imm, out_ready, err_clr,
      input  in_ready, out_valid, out_enc, out_mask, out_err, err_cnt
   );

   modport slave (
      input  in_valid, imm_src, imm, out_ready, err_clr,
      output in_ready, out_valid, out_enc, out_mask, out_err, err_cnt
   );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage immediate encoder producing instr[31:7], mask and range errors
// Optional S2 round-trip re-extension check is built when IMM_ROUNDTRIP_CHECK_EN is defined.
module imm_encoder #(
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   imm_encoder_if.slave bus
);
   localparam logic [2:0] SRC_I = 3'd0;
   localparam logic [2:0] SRC_S = 3'd1;
   localparam logic [2:0] SRC_B = 3'd2;
   localparam logic [2:0] SRC_J = 3'd3;
   localparam logic [2:0] SRC_U = 3'd4;

   logic             s1_valid;
   logic             s2_valid;
   logic             s1_adv;
   logic             s2_adv;
   logic [2:0]       s1_src;
   logic [31:0]      s1_imm;
   logic [24:0]      enc;
   logic [24:0]      mask;
   logic             rng_err;
   logic [24:0]      s2_enc;
   logic [24:0]      s2_mask;
   logic             s2_rng_err;
   logic             rt_err;
   logic             xfer_err;
   logic [CNT_W-1:0] cnt;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_src   <= '0;
         s1_imm   <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_src <= bus.imm_src;
            s1_imm <= bus.imm;
         end
      end
   end

   // Out-of-range values still emit their truncated fields; only the flag is added.
   always_comb begin
      enc     = '0;
      mask    = '0;
      rng_err = 1'b0;
      case (s1_src)
         SRC_I: begin
            enc[24:13]  = s1_imm[11:0];
            mask[24:13] = '1;
            rng_err     = s1_imm[31:11] != {21{s1_imm[31]}};
         end
         SRC_S: begin
            enc[24:18]  = s1_imm[11:5];
            enc[4:0]    = s1_imm[4:0];
            mask[24:18] = '1;
            mask[4:0]   = '1;
            rng_err     = s1_imm[31:11] != {21{s1_imm[31]}};
         end
         SRC_B: begin
            enc[24]     = s1_imm[12];
            enc[23:18]  = s1_imm[10:5];
            enc[4:1]    = s1_imm[4:1];
            enc[0]      = s1_imm[11];
            mask[24:18] = '1;
            mask[4:0]   = '1;
            rng_err     = (s1_imm[31:12] != {20{s1_imm[31]}}) || s1_imm[0];
         end
         SRC_J: begin
            enc[24]     = s1_imm[20];
            enc[23:14]  = s1_imm[10:1];
            enc[13]     = s1_imm[11];
            enc[12:5]   = s1_imm[19:12];
            mask[24:5]  = '1;
            rng_err     = (s1_imm[31:20] != {12{s1_imm[31]}}) || s1_imm[0];
         end
         SRC_U: begin
            enc[24:5]   = s1_imm[31:12];
            mask[24:5]  = '1;
            rng_err     = s1_imm[11:0] != 12'h000;
         end
         default: begin
            rng_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         s2_enc     <= '0;
         s2_mask    <= '0;
         s2_rng_err <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_enc     <= enc;
            s2_mask    <= mask;
            s2_rng_err <= rng_err;
         end
      end
   end

`ifdef IMM_ROUNDTRIP_CHECK_EN
   logic [2:0]  s2_src;
   logic [31:0] s2_imm;
   logic [31:0] ext;
   logic        legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_src <= '0;
         s2_imm <= '0;
      end else if (s2_adv && s1_valid) begin
         s2_src <= s1_src;
         s2_imm <= s1_imm;
      end
   end

   // Decode the held instruction bits back to a 32-bit immediate, as the core would.
   always_comb begin
      ext   = '0;
      legal = 1'b1;
      case (s2_src)
         SRC_I:   ext = {{20{s2_enc[24]}}, s2_enc[24:13]};
         SRC_S:   ext = {{20{s2_enc[24]}}, s2_enc[24:18], s2_enc[4:0]};
         SRC_B:   ext = {{19{s2_enc[24]}}, s2_enc[24], s2_enc[0], s2_enc[23:18],
                         s2_enc[4:1], 1'b0};
         SRC_J:   ext = {{11{s2_enc[24]}}, s2_enc[24], s2_enc[12:5], s2_enc[13],
                         s2_enc[23:14], 1'b0};
         SRC_U:   ext = {s2_enc[24:5], 12'h000};
         default: legal = 1'b0;
      endcase
   end

   assign rt_err = legal && (ext != s2_imm);
`else
   assign rt_err = 1'b0;
`endif

   assign bus.out_valid = s2_valid;
   assign bus.out_enc   = s2_enc;
   assign bus.out_mask  = s2_mask;
   assign bus.out_err   = {rt_err, s2_rng_err};

   assign xfer_err = s2_valid && bus.out_ready && (s2_rng_err || rt_err);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (bus.err_clr) begin
         cnt <= '0;
      end else if (xfer_err && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.err_cnt = cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - vector table, directed corner sequences and randomized scoreboard for imm_encoder
module tb_imm_encoder;
   localparam int CNT_W = 8;
`ifdef IMM_ROUNDTRIP_CHECK_EN
   localparam bit RT_EN = 1'b1;
`else
   localparam bit RT_EN = 1'b0;
`endif

   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      logic [24:0] enc;
      logic [24:0] mask;
      logic [1:0]  err;
   } tv_t;

   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      bit          has_enc;
      logic [24:0] enc;
      logic [24:0] mask;
      logic [1:0]  err;
      logic [31:0] tgt;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n;
   bit   rdy_mode;
   logic rdy_man;
   logic rnd_rdy;
   bit   mon_en;
   int   exp_cnt;
   int   n_cmp = 0;
   int   n_fail = 0;
   rec_t exp_q[$];
   tv_t  tv[12];

   always #5 clk = ~clk;

   imm_encoder_if #(.CNT_W(CNT_W)) bus ();

   imm_encoder #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.out_ready = rdy_mode ? rnd_rdy : rdy_man;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sign-extend the low w bits of v with plain modular arithmetic.
   function automatic logic [31:0] sx(logic [31:0] v, int w);
      logic [31:0] b;
      b = 32'd1 << (w - 1);
      return (v ^ b) - b;
   endfunction

   function automatic logic [31:0] ext(logic [2:0] s, logic [24:0] d);
      case (s)
         3'd0:    return sx({20'b0, d[24:13]}, 12);
         3'd1:    return sx({20'b0, d[24:18], d[4:0]}, 12);
         3'd2:    return sx({19'b0, d[24], d[0], d[23:18], d[4:1], 1'b0}, 13);
         3'd3:    return sx({11'b0, d[24], d[12:5], d[13], d[23:14], 1'b0}, 21);
         3'd4:    return {d[24:5], 12'h000};
         default: return 32'h0;
      endcase
   endfunction

   function automatic rec_t model(logic [2:0] s, logic [31:0] v);
      rec_t r;
      r.src = s; r.imm = v; r.has_enc = 1'b0; r.enc = '0; r.mask = '0; r.err = '0; r.tgt = '0;
      case (s)
         3'd0, 3'd1: begin
            r.mask   = (s == 3'd0) ? 25'h1FFE000 : 25'h1FC001F;
            r.tgt    = sx(v & 32'hFFF, 12);
            r.err[0] = (v + 32'd2048) >= 32'd4096;
         end
         3'd2: begin
            r.mask   = 25'h1FC001F;
            r.tgt    = sx(v & 32'h1FFE, 13);
            r.err[0] = ((v + 32'd4096) >= 32'd8192) || (v % 2 != 0);
         end
         3'd3: begin
            r.mask   = 25'h1FFFFE0;
            r.tgt    = sx(v & 32'h1FFFFE, 21);
            r.err[0] = ((v + 32'h100000) >= 32'h200000) || (v % 2 != 0);
         end
         3'd4: begin
            r.mask   = 25'h1FFFFE0;
            r.tgt    = v & 32'hFFFFF000;
            r.err[0] = (v % 4096) != 0;
         end
         default: begin
            r.has_enc = 1'b1;
            r.err[0]  = 1'b1;
         end
      endcase
      if (s <= 3'd4) r.err[1] = RT_EN && (r.tgt != v);
      return r;
   endfunction

   // Offer one request (caller sits just after a rising edge); returns just after the accepting edge.
   task automatic send(logic [2:0] s, logic [31:0] v, rec_t e);
      int t;
      bus.in_valid = 1'b1;
      bus.imm_src  = s;
      bus.imm      = v;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) check("accept_timeout", bus.in_ready, 1);
      else exp_q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic rand_phase(int n);
      logic [2:0]  s;
      logic [31:0] v;
      int          w;
      for (int i = 0; i < n; i++) begin
         s = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         w = $urandom_range(1, 32);
         v = $urandom;
         if (w < 32) v = sx(v & ((32'd1 << w) - 1), w);
         if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
         if (s == 3'd4 && $urandom_range(0, 1) == 1) v[11:0] = 12'h000;
         send(s, v, model(s, v));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      rnd_rdy = ($urandom_range(0, 99) < 60);
   end

   // Output monitor: pops the scoreboard on each transfer and tracks the error counter.
   initial forever begin
      rec_t r;
      bit   xe;
      @(negedge clk);
      if (mon_en) begin
         xe = 1'b0;
         check("err_cnt", bus.err_cnt, exp_cnt);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("out_unexpected", bus.out_valid, 0);
            end else begin
               r = exp_q.pop_front();
               if (r.has_enc) begin
                  check("out_enc", bus.out_enc, r.enc);
               end else begin
                  check("out_enc_roundtrip", ext(r.src, bus.out_enc), r.tgt);
                  check("out_enc_outside_mask", bus.out_enc & ~r.mask, 0);
               end
               check("out_mask", bus.out_mask, r.mask);
               check("out_err", bus.out_err, r.err);
               xe = |r.err;
            end
         end
         if (bus.err_clr) exp_cnt = 0;
         else if (xe && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r;
      int   t;
      bus.in_valid = 1'b0; bus.imm_src = '0; bus.imm = '0; bus.err_clr = 1'b0;
      rdy_mode = 1'b0; rdy_man = 1'b1; rst_n = 1'b0; mon_en = 1'b0; exp_cnt = 0;

      tv[0]  = '{3'd0, 32'hFFFFF800, 25'h1000000, 25'h1FFE000, 2'b00};
      tv[1]  = '{3'd2, 32'h00000FFE, 25'h0FC001F, 25'h1FC001F, 2'b00};
      tv[2]  = '{3'd4, 32'h12345000, 25'h02468A0, 25'h1FFFFE0, 2'b00};
      tv[3]  = '{3'd4, 32'h12345001, 25'h02468A0, 25'h1FFFFE0, {RT_EN, 1'b1}};
      tv[4]  = '{3'd7, 32'h12345678, 25'h0000000, 25'h0000000, 2'b01};
      tv[5]  = '{3'd3, 32'h00000001, 25'h0000000, 25'h1FFFFE0, {RT_EN, 1'b1}};
      tv[6]  = '{3'd1, 32'hFFFFFFFF, 25'h1FC001F, 25'h1FC001F, 2'b00};
      tv[7]  = '{3'd3, 32'hFFF00000, 25'h1000000, 25'h1FFFFE0, 2'b00};
      tv[8]  = '{3'd0, 32'h00000800, 25'h1000000, 25'h1FFE000, {RT_EN, 1'b1}};
      tv[9]  = '{3'd3, 32'h000FFFFE, 25'h0FFFFE0, 25'h1FFFFE0, 2'b00};
      tv[10] = '{3'd2, 32'hFFFFF000, 25'h1000000, 25'h1FC001F, 2'b00};
      tv[11] = '{3'd5, 32'h00000000, 25'h0000000, 25'h0000000, 2'b01};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_enc", bus.out_enc, 0);
      check("rst_out_mask", bus.out_mask, 0);
      check("rst_out_err", bus.out_err, 0);
      check("rst_err_cnt", bus.err_cnt, 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      mon_en = 1'b1;

      for (int i = 0; i < 12; i++) begin
         r.src = tv[i].src; r.imm = tv[i].imm; r.has_enc = 1'b1;
         r.enc = tv[i].enc; r.mask = tv[i].mask; r.err = tv[i].err; r.tgt = '0;
         send(tv[i].src, tv[i].imm, r);
      end
      drain();

      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      check("err_clr_alone", bus.err_cnt, 0);
      @(posedge clk); #1;
      send(3'd3, 32'h1, model(3'd3, 32'h1));
      drain();
      @(negedge clk);
      check("err_cnt_inc", bus.err_cnt, 1);
      @(posedge clk); #1;
      rdy_man = 1'b0;
      send(3'd3, 32'h1, model(3'd3, 32'h1));
      t = 0;
      while (!bus.out_valid && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      check("err_pending_valid", bus.out_valid, 1);
      rdy_man = 1'b1;
      bus.err_clr = 1'b1;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      @(negedge clk);
      check("err_clr_prio", bus.err_cnt, 0);
      @(posedge clk); #1;
      drain();

      rdy_man = 1'b0;
      bus.in_valid = 1'b1; bus.imm_src = 3'd4; bus.imm = 32'h12345000;
      @(negedge clk);
      check("bp_accept_a", bus.in_ready, 1);
      exp_q.push_back(model(3'd4, 32'h12345000));
      @(posedge clk); #1;
      bus.imm_src = 3'd0; bus.imm = 32'hFFFFF800;
      @(negedge clk);
      check("bp_accept_b", bus.in_ready, 1);
      exp_q.push_back(model(3'd0, 32'hFFFFF800));
      @(posedge clk); #1;
      bus.imm_src = 3'd2; bus.imm = 32'h00000FFE;
      @(negedge clk);
      check("bp_full", bus.in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_full_hold", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_stable", bus.out_enc, 25'h02468A0);
      check("bp_queued", exp_q.size(), 2);
      @(posedge clk); #1;
      rdy_man = 1'b1;
      @(negedge clk);
      check("bp_release", bus.in_ready, 1);
      exp_q.push_back(model(3'd2, 32'h00000FFE));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain();

      rdy_mode = 1'b1;
      rand_phase(400);
      drain();
      rdy_mode = 1'b0;
      rdy_man = 1'b1;

      for (int i = 0; i < 260; i++) send(3'd7, 32'($urandom), model(3'd7, 32'h0));
      drain();
      @(negedge clk);
      check("err_cnt_sat", bus.err_cnt, 255);
      @(posedge clk); #1;

      rdy_man = 1'b0;
      send(3'd0, 32'h5, model(3'd0, 32'h5));
      send(3'd1, 32'h7, model(3'd1, 32'h7));
      check("mid_full_valid", bus.out_valid, 1);
      check("mid_full_ready", bus.in_ready, 0);
      mon_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_err_cnt", bus.err_cnt, 0);
      check("mid_rst_out_enc", bus.out_enc, 0);
      exp_q.delete();
      exp_cnt = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rdy_man = 1'b1;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1);
      mon_en = 1'b1;
      @(posedge clk); #1;
      send(3'd0, 32'h3, model(3'd0, 32'h3));
      @(negedge clk);
      check("lat_after_1", bus.out_valid, 0);
      @(negedge clk);
      check("lat_after_2", bus.out_valid, 1);
      @(posedge clk); #1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
